// File: rtl/zed64_mem_pkg.sv
// Shared definitions for the 64 KiB x 8 dual-port RAM and its bus initiators.
package zed64_mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 8;
    localparam int RAM_SIZE   = 65536;

    // Block mover sequencing: read phase, optional read-latency wait, write phase.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_FIN
    } mover_state_t;

endpackage

// File: rtl/dpram_addr_stepper.sv
// Address pointer: loads a start address plus direction, then steps by one with
// natural wrap at the top/bottom of the address space.
module dpram_addr_stepper #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_down,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_ptr,
    output logic [ADDR_W-1:0] o_ptr_next
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_down;

    // Modular +/-1; truncation to ADDR_W bits provides the wrap.
    assign o_ptr_next = r_down ? (r_ptr - ADDR_W'(1)) : (r_ptr + ADDR_W'(1));
    assign o_ptr      = r_ptr;

    // Pointer register: load wins over step; direction is fixed per transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_ptr  <= i_load_val;
            r_down <= i_down;
        end else if (i_step) begin
            r_ptr  <= o_ptr_next;
        end
    end

endmodule

// File: rtl/dpram_block_mover.sv
// Copy/fill engine for one port of the dual-port RAM. Overlapping copies run
// backward so the source is never overwritten before it is read.
module dpram_block_mover
    import zed64_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   remaining,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wena,
    output logic              mem_oe,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] LAT_C = 2'(RD_LAT);

    mover_state_t      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_wena;
    logic              r_abort_seen;
    logic              r_fill;
    logic [1:0]        r_wait_cnt;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W-1:0] r_mem_addr;
    // Write data register also serves as the read hold register.
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_start;
    logic              w_backward;
    logic              w_stop;
    logic [ADDR_W-1:0] w_delta;
    logic [ADDR_W-1:0] w_len_m1;
    logic [ADDR_W-1:0] w_src_start;
    logic [ADDR_W-1:0] w_dst_start;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_src_next;
    logic [ADDR_W-1:0] w_dst_ptr;
    logic [ADDR_W-1:0] w_dst_next;
    logic [ADDR_W:0]   w_rem_next;

    assign w_start     = (r_state == ST_IDLE) && start;
    // Destination lies inside the source window ahead of src: copy from the top down.
    assign w_delta     = dst_addr - src_addr;
    assign w_backward  = !fill_mode && ({1'b0, w_delta} < length) && (dst_addr != src_addr);
    assign w_len_m1    = length[ADDR_W-1:0] - ADDR_W'(1);
    assign w_src_start = w_backward ? (src_addr + w_len_m1) : src_addr;
    assign w_dst_start = w_backward ? (dst_addr + w_len_m1) : dst_addr;
    assign w_rem_next  = r_remaining - (ADDR_W+1)'(1);
    assign w_stop      = (w_rem_next == '0) || r_abort_seen || abort;

    dpram_addr_stepper #(.ADDR_W(ADDR_W)) u_src_ptr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start),
        .i_load_val (w_src_start),
        .i_down     (w_backward),
        .i_step     (r_state == ST_WR),
        .o_ptr      (w_src_ptr),
        .o_ptr_next (w_src_next)
    );

    dpram_addr_stepper #(.ADDR_W(ADDR_W)) u_dst_ptr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start),
        .i_load_val (w_dst_start),
        .i_down     (w_backward),
        .i_step     (r_state == ST_WR),
        .o_ptr      (w_dst_ptr),
        .o_ptr_next (w_dst_next)
    );

    // Sequencer; bus outputs are registered so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_wena   <= 1'b0;
            r_abort_seen <= 1'b0;
            r_fill       <= 1'b0;
            r_wait_cnt   <= '0;
            r_remaining  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_abort_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining  <= length;
                        r_abort_seen <= 1'b0;
                        r_fill       <= fill_mode;
                        if (length == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else if (fill_mode) begin
                            r_state     <= ST_WR;
                            r_busy      <= 1'b1;
                            r_mem_addr  <= w_dst_start;
                            r_mem_wena  <= 1'b1;
                            r_mem_wdata <= fill_value;
                        end else begin
                            r_state    <= ST_RD;
                            r_busy     <= 1'b1;
                            r_mem_addr <= w_src_start;
                        end
                    end
                end
                ST_RD: begin
                    if (LAT_C == 2'd0) begin
                        r_mem_wdata <= mem_rdata;
                        r_state     <= ST_WR;
                        r_mem_addr  <= w_dst_ptr;
                        r_mem_wena  <= 1'b1;
                    end else begin
                        r_state    <= ST_RWAIT;
                        r_wait_cnt <= 2'd1;
                    end
                end
                ST_RWAIT: begin
                    if (r_wait_cnt == LAT_C) begin
                        r_mem_wdata <= mem_rdata;
                        r_state     <= ST_WR;
                        r_mem_addr  <= w_dst_ptr;
                        r_mem_wena  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                ST_WR: begin
                    r_remaining <= w_rem_next;
                    if (w_stop) begin
                        r_state    <= ST_FIN;
                        r_mem_wena <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (r_fill) begin
                        r_mem_addr <= w_dst_next;
                    end else begin
                        r_state    <= ST_RD;
                        r_mem_wena <= 1'b0;
                        r_mem_addr <= w_src_next;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_wena <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;
    assign mem_addr  = r_mem_addr;
    assign mem_wena  = r_mem_wena;
    assign mem_oe    = r_mem_wena;
    assign mem_wdata = r_mem_wdata;

endmodule
